// File: rtl/step_dir_timing.sv
// -----------------------------------------------------------------------------
// step_dir_timing
//   Output conditioner between a step generator's STP/DIR pair and the pins of
//   an external stepper driver. Every rising edge of step_in is one requested
//   step, accumulated as a signed pending count. Queued steps are replayed as
//   driver-legal pulses (minimum high time, minimum space, DIR setup and hold
//   around every reversal). The position of the issued steps is also kept.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   step_in   in   raw STP, rising edge = one step request
//   dir_in    in   raw DIR (1 = positive), sampled with the step_in edge
//   enable    in   1 = issue queued steps, 0 = stop after the current pulse
//   clr_ovf   in   clears the sticky overflow flag
//   step_out  out  conditioned step pulse
//   dir_out   out  conditioned direction
//   busy      out  1 whenever the sequencer is not idle
//   overflow  out  sticky, set when a request is dropped at the pending limit
//   pending   out  signed count of queued, not yet issued steps
//   position  out  signed count of issued steps, wraps modulo 2^32
// -----------------------------------------------------------------------------
module step_dir_timing #(
   parameter int STEP_LEN   = 100,
   parameter int STEP_SPACE = 100,
   parameter int DIR_SETUP  = 50,
   parameter int DIR_HOLD   = 50,
   parameter int PEND_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     step_in,
   input  logic                     dir_in,
   input  logic                     enable,
   input  logic                     clr_ovf,
   output logic                     step_out,
   output logic                     dir_out,
   output logic                     busy,
   output logic                     overflow,
   output logic signed [PEND_W-1:0] pending,
   output logic signed [31:0]       position
);

   localparam int PMAX    = (1 << (PEND_W - 1)) - 1;
   localparam int CNT_M1  = (STEP_LEN > STEP_SPACE) ? STEP_LEN : STEP_SPACE;
   localparam int CNT_MAX = (CNT_M1 > DIR_SETUP) ? CNT_M1 : DIR_SETUP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int HOLD_W  = $clog2(DIR_HOLD + 1);
   // Two guard bits so pending +/- both deltas can never wrap before the limit test.
   localparam int EXT_W   = PEND_W + 2;

   localparam logic signed [EXT_W-1:0] PMAX_X = EXT_W'(PMAX);
   localparam logic signed [EXT_W-1:0] ONE_X  = EXT_W'(1);
   localparam logic signed [EXT_W-1:0] ZERO_X = '0;
   localparam logic [HOLD_W-1:0]       HOLD_X = HOLD_W'(DIR_HOLD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIR_WAIT,
      S_DIR_SETUP,
      S_STEP_HIGH,
      S_STEP_LOW
   } state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [HOLD_W-1:0]          hold_q, hold_d;
   logic                       step_in_q, step_in_d;
   logic                       step_out_q, step_out_d;
   logic                       dir_out_q, dir_out_d;
   logic                       ovf_q, ovf_d;
   logic signed [PEND_W-1:0]   pend_q, pend_d;
   logic signed [31:0]         pos_q, pos_d;

   logic                       rise;
   logic                       commit;
   logic                       drop;
   logic                       pend_zero;
   logic                       dir_match;
   logic signed [EXT_W-1:0]    pend_ext;
   logic signed [EXT_W-1:0]    in_delta;
   logic signed [EXT_W-1:0]    out_delta;
   logic signed [EXT_W-1:0]    pend_full;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      dir_out_d  = dir_out_q;
      pos_d      = pos_q;
      commit     = 1'b0;
      out_delta  = ZERO_X;
      step_in_d  = step_in;

      rise      = step_in & ~step_in_q;
      in_delta  = rise ? (dir_in ? ONE_X : -ONE_X) : ZERO_X;
      pend_zero = (pend_q == '0);
      // A nonzero pending count agrees with dir_out when its sign is the direction.
      dir_match = (~pend_q[PEND_W-1]) == dir_out_q;

      unique case (state_q)
         S_IDLE: begin
            if (enable && !pend_zero) begin
               if (dir_match) commit  = 1'b1;
               else           state_d = S_DIR_WAIT;
            end
         end
         S_DIR_WAIT: begin
            if (pend_zero) begin
               state_d = S_IDLE;
            end else if (hold_q == HOLD_X) begin
               dir_out_d = ~pend_q[PEND_W-1];
               cnt_d     = '0;
               state_d   = S_DIR_SETUP;
            end
         end
         S_DIR_SETUP: begin
            if (cnt_q == CNT_W'(DIR_SETUP - 1)) begin
               // Requests may have arrived during setup, so re-check before issuing.
               if (pend_zero)       state_d = S_IDLE;
               else if (!dir_match) state_d = S_DIR_WAIT;
               else                 commit  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STEP_HIGH: begin
            if (cnt_q == CNT_W'(STEP_LEN - 1)) begin
               cnt_d   = '0;
               state_d = S_STEP_LOW;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STEP_LOW: begin
            if (cnt_q == CNT_W'(STEP_SPACE - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (commit) begin
         state_d   = S_STEP_HIGH;
         cnt_d     = '0;
         out_delta = dir_out_q ? ONE_X : -ONE_X;
         pos_d     = pos_q + (dir_out_q ? 32'sd1 : -32'sd1);
      end

      // step_out is registered from the next state so the pin never glitches.
      step_out_d = (state_d == S_STEP_HIGH);

      hold_d = hold_q;
      if (step_out_q && !step_out_d) hold_d = '0;
      else if (hold_q != HOLD_X)     hold_d = hold_q + HOLD_W'(1);

      // The committed step always moves pending toward zero, so only in_delta
      // can push it past the limit; that request is the one dropped.
      pend_ext  = {{2{pend_q[PEND_W-1]}}, pend_q};
      pend_full = pend_ext + in_delta - out_delta;
      drop      = (pend_full > PMAX_X) || (pend_full < -PMAX_X);
      pend_d    = drop ? PEND_W'(pend_ext - out_delta) : pend_full[PEND_W-1:0];

      // A new overflow event outranks a clear in the same cycle.
      ovf_d = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         hold_q     <= HOLD_X;   // first reversal after reset is not delayed
         step_in_q  <= 1'b0;
         step_out_q <= 1'b0;
         dir_out_q  <= 1'b0;
         ovf_q      <= 1'b0;
         pend_q     <= '0;
         pos_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         step_in_q  <= step_in_d;
         step_out_q <= step_out_d;
         dir_out_q  <= dir_out_d;
         ovf_q      <= ovf_d;
         pend_q     <= pend_d;
         pos_q      <= pos_d;
      end
   end

   assign step_out = step_out_q;
   assign dir_out  = dir_out_q;
   assign busy     = (state_q != S_IDLE);
   assign overflow = ovf_q;
   assign pending  = pend_q;
   assign position = pos_q;

endmodule
